alu_cmd_driver: RTL and testbench

Host-side driver for the 8-bit pin-level ALU (tt_um_8bitALU). It accepts operation requests over a valid/ready interface and buffers them in a small FIFO. Each request is encoded onto the ALU's 8-bit instruction pins with a one-cycle enable pulse; after the ALU latency the driver captures the ALU output byte. It checks the echoed opcode and returns the result over a valid/ready response interface.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_driver_if.sv | 25 ++
 rtl/alu_req_fifo.sv | 50 +++++
 rtl/alu_cmd_driver.sv | 148 ++++++++++++++
 tb/tb_alu_cmd_driver.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings, field positions and FSM states for the ALU command driver
package alu_pkg;

  localparam int OP_W  = 2;
  localparam int OPND_W = 3;
  localparam int RES_W = 6;
  localparam int INSTR_W = 8;

  localparam int ALU_A_LSB  = 0;
  localparam int ALU_B_LSB  = 3;
  localparam int ALU_OP_LSB = 6;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Pin order expected by the ALU: {op, b, a}
  function automatic logic [INSTR_W-1:0] pack_instr(input logic [OP_W-1:0] op,
                                                    input logic [OPND_W-1:0] a,
                                                    input logic [OPND_W-1:0] b);
    return {op, b, a};
  endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// rtl/alu_cmd_driver_if.sv - request/response handshake bundle between host and ALU driver
interface alu_cmd_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] req_a;
  logic [2:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [5:0] rsp_data;
  logic       rsp_err;
  logic       rsp_borrow;

  // Host side: issues requests, consumes responses
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_borrow
  );

  // Driver side
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_borrow
  );
endinterface

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - small synchronous request FIFO with full/empty flags
module alu_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  logic do_push;
  logic do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Read port shows stored data only, so a same-cycle write is never forwarded
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update; reset flushes all queued entries
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - queues ALU requests, drives ALU pins, returns checked results
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_cmd_driver_if.slave    cmd,
  output logic [INSTR_W-1:0] alu_in,
  output logic               alu_ena,
  input  logic [INSTR_W-1:0] alu_out,
  output logic               busy
);
  localparam logic [2:0] LAST_WAIT = 3'(ALU_LAT - 1);

  state_t state_q;
  state_t state_d;

  logic [INSTR_W-1:0] fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;

  logic [OP_W-1:0]    op_q;
  logic [OPND_W-1:0]  a_q;
  logic [OPND_W-1:0]  b_q;
  logic [2:0]         wait_cnt;
  logic [RES_W-1:0]   rsp_data_q;
  logic               rsp_err_q;
  logic               rsp_borrow_q;
  logic               rsp_valid_c;
  logic               busy_c;

  logic [OP_W-1:0]    head_op;
  logic [OPND_W-1:0]  head_a;
  logic [OPND_W-1:0]  head_b;
  logic               head_div0;
  logic               wait_last;

  assign cmd.req_ready = !fifo_full && !rst;
  assign fifo_push     = cmd.req_valid && cmd.req_ready;
  assign fifo_pop      = (state_q == IDLE) && !fifo_empty;

  assign head_op   = fifo_rd[ALU_OP_LSB +: OP_W];
  assign head_a    = fifo_rd[ALU_A_LSB +: OPND_W];
  assign head_b    = fifo_rd[ALU_B_LSB +: OPND_W];
  assign head_div0 = (head_op == OP_DIV) && (head_b == '0);
  assign wait_last = (wait_cnt == LAST_WAIT);

  alu_req_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (pack_instr(cmd.req_op, cmd.req_a, cmd.req_b)),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs
  always_comb begin
    state_d     = state_q;
    rsp_valid_c = 1'b0;
    busy_c      = (state_q != IDLE) || !fifo_empty;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = head_div0 ? RESP : ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_last) state_d = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (cmd.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, ALU pin drive and result capture; alu_in is loaded on
  // the pop edge so it is already valid in ISSUE and held through WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_in       <= '0;
      alu_ena      <= 1'b0;
      wait_cnt     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rsp_borrow_q <= 1'b0;
    end else begin
      alu_ena <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            op_q <= head_op;
            a_q  <= head_a;
            b_q  <= head_b;
            if (head_div0) begin
              rsp_data_q   <= '0;
              rsp_err_q    <= 1'b1;
              rsp_borrow_q <= 1'b0;
            end else begin
              alu_in  <= fifo_rd;
              alu_ena <= 1'b1;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_last) begin
            rsp_data_q   <= alu_out[RES_W-1:0];
            rsp_err_q    <= (alu_out[ALU_OP_LSB +: OP_W] != op_q);
            rsp_borrow_q <= (op_q == OP_SUB) && (a_q < b_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd.rsp_valid  = rsp_valid_c;
  assign cmd.rsp_data   = rsp_data_q;
  assign cmd.rsp_err    = rsp_err_q;
  assign cmd.rsp_borrow = rsp_borrow_q;
  assign busy           = busy_c;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - directed self-checking bench for alu_cmd_driver
module tb_alu_cmd_driver;
  logic       clk;
  logic       rst;
  logic [7:0] alu_in;
  logic       alu_ena;
  logic [7:0] alu_out;
  logic       busy;

  int n_checks;
  int n_fail;

  alu_cmd_driver_if cmd_if ();

  alu_cmd_driver #(
    .REQ_DEPTH (4),
    .ALU_LAT   (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd_if),
    .alu_in  (alu_in),
    .alu_ena (alu_ena),
    .alu_out (alu_out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pin-level ALU model: result registered one cycle after ena, opcode echoed combinationally
  logic [5:0] alu_res;
  logic       corrupt_add;

  function automatic logic [5:0] alu_compute(input logic [7:0] ins);
    logic [1:0] op;
    logic [5:0] a;
    logic [5:0] b;
    op = ins[7:6];
    a  = {3'b000, ins[2:0]};
    b  = {3'b000, ins[5:3]};
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return (b == 6'd0) ? 6'd0 : a / b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_ena) alu_res <= alu_compute(alu_in);
  end

  always_comb begin
    alu_out = {alu_in[7:6], alu_res};
    if (corrupt_add && alu_in[7:6] == 2'b00) alu_out[7:6] = 2'b11;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request from an idle driver; exp_ena_cyc=0 means no ALU access expected
  task automatic do_op(input string tag, input logic [1:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic [7:0] exp_in,
                       input logic [5:0] exp_data, input logic exp_err,
                       input logic exp_borrow, input int exp_ena_cyc, input int exp_rsp_cyc);
    int ena_cnt;
    int ena_cyc;
    int rsp_cyc;
    ena_cnt = 0;
    ena_cyc = 0;
    rsp_cyc = 0;
    @(negedge clk);
    cmd_if.req_op    = op;
    cmd_if.req_a     = a;
    cmd_if.req_b     = b;
    cmd_if.req_valid = 1'b1;
    cmd_if.rsp_ready = 1'b1;
    #1;
    check_eq({tag, "_req_ready"}, 32'(cmd_if.req_ready), 32'd1);
    @(posedge clk);
    #1 cmd_if.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (alu_ena) begin
        ena_cnt++;
        ena_cyc = c;
      end
      if (exp_ena_cyc != 0 && c >= exp_ena_cyc)
        check_eq({tag, "_alu_in"}, 32'(alu_in), 32'(exp_in));
      if (cmd_if.rsp_valid) begin
        rsp_cyc = c;
        break;
      end
    end
    check_eq({tag, "_ena_count"}, 32'(ena_cnt), (exp_ena_cyc != 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_ena_cycle"}, 32'(ena_cyc), 32'(exp_ena_cyc));
    check_eq({tag, "_rsp_cycle"}, 32'(rsp_cyc), 32'(exp_rsp_cyc));
    check_eq({tag, "_rsp_data"}, 32'(cmd_if.rsp_data), 32'(exp_data));
    check_eq({tag, "_rsp_err"}, 32'(cmd_if.rsp_err), 32'(exp_err));
    check_eq({tag, "_rsp_borrow"}, 32'(cmd_if.rsp_borrow), 32'(exp_borrow));
    @(negedge clk);
    check_eq({tag, "_rsp_drop"}, 32'(cmd_if.rsp_valid), 32'd0);
  endtask

  logic [1:0] bp_op   [6];
  logic [2:0] bp_a    [6];
  logic [2:0] bp_b    [6];
  logic [5:0] bp_data [5];
  logic       bp_brw  [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ena_seen;
    int stray;
    logic hs;
    n_checks = 0;
    n_fail   = 0;
    corrupt_add      = 1'b0;
    alu_res          = 6'd0;
    rst              = 1'b1;
    cmd_if.req_valid = 1'b0;
    cmd_if.req_op    = 2'b00;
    cmd_if.req_a     = 3'd0;
    cmd_if.req_b     = 3'd0;
    cmd_if.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_alu_in", 32'(alu_in), 32'd0);
    check_eq("rst_alu_ena", 32'(alu_ena), 32'd0);
    check_eq("rst_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(cmd_if.rsp_data), 32'd0);
    check_eq("rst_rsp_err", 32'(cmd_if.rsp_err), 32'd0);
    check_eq("rst_rsp_borrow", 32'(cmd_if.rsp_borrow), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ready", 32'(cmd_if.req_ready), 32'd0);
    rst = 1'b0;
    #1 check_eq("post_rst_req_ready", 32'(cmd_if.req_ready), 32'd1);

    // Directed single operations with hand-computed pin and result values
    do_op("add34", 2'b00, 3'd3, 3'd4, 8'h23, 6'd7,  1'b0, 1'b0, 2, 4);
    do_op("sub25", 2'b01, 3'd2, 3'd5, 8'h6A, 6'd61, 1'b0, 1'b1, 2, 4);
    do_op("mul77", 2'b10, 3'd7, 3'd7, 8'hBF, 6'd49, 1'b0, 1'b0, 2, 4);
    do_op("div60", 2'b11, 3'd6, 3'd0, 8'h00, 6'd0,  1'b1, 1'b0, 0, 2);
    do_op("div72", 2'b11, 3'd7, 3'd2, 8'hD7, 6'd3,  1'b0, 1'b0, 2, 4);
    corrupt_add = 1'b1;
    do_op("add_bad_echo", 2'b00, 3'd1, 3'd2, 8'h11, 6'd3, 1'b1, 1'b0, 2, 4);
    corrupt_add = 1'b0;

    // Backpressure: 1 in FSM + 4 in FIFO, sixth refused
    bp_op[0] = 2'b00; bp_a[0] = 3'd1; bp_b[0] = 3'd2; bp_data[0] = 6'd3;  bp_brw[0] = 1'b0;
    bp_op[1] = 2'b01; bp_a[1] = 3'd0; bp_b[1] = 3'd1; bp_data[1] = 6'd63; bp_brw[1] = 1'b1;
    bp_op[2] = 2'b10; bp_a[2] = 3'd3; bp_b[2] = 3'd5; bp_data[2] = 6'd15; bp_brw[2] = 1'b0;
    bp_op[3] = 2'b11; bp_a[3] = 3'd7; bp_b[3] = 3'd3; bp_data[3] = 6'd2;  bp_brw[3] = 1'b0;
    bp_op[4] = 2'b00; bp_a[4] = 3'd7; bp_b[4] = 3'd7; bp_data[4] = 6'd14; bp_brw[4] = 1'b0;
    bp_op[5] = 2'b10; bp_a[5] = 3'd6; bp_b[5] = 3'd6;
    cmd_if.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_if.req_op    = bp_op[i];
      cmd_if.req_a     = bp_a[i];
      cmd_if.req_b     = bp_b[i];
      cmd_if.req_valid = 1'b1;
      #1 check_eq("bp_push_ready", 32'(cmd_if.req_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    cmd_if.req_op = bp_op[5];
    cmd_if.req_a  = bp_a[5];
    cmd_if.req_b  = bp_b[5];
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("bp_full_ready", 32'(cmd_if.req_ready), 32'd0);
      @(negedge clk);
    end
    cmd_if.req_valid = 1'b0;
    check_eq("bp_busy", 32'(busy), 32'd1);
    check_eq("bp_held_valid", 32'(cmd_if.rsp_valid), 32'd1);

    // Drain with random stalls; every cycle with rsp_valid must show the expected head
    k = 0;
    for (int c = 0; c < 300 && k < 5; c++) begin
      @(negedge clk);
      if (cmd_if.rsp_valid) begin
        check_eq("bp_rsp_data", 32'(cmd_if.rsp_data), 32'(bp_data[k]));
        check_eq("bp_rsp_err", 32'(cmd_if.rsp_err), 32'd0);
        check_eq("bp_rsp_borrow", 32'(cmd_if.rsp_borrow), 32'(bp_brw[k]));
      end
      cmd_if.rsp_ready = 1'($urandom_range(0, 1));
      hs = cmd_if.rsp_valid && cmd_if.rsp_ready;
      @(posedge clk);
      if (hs) k++;
    end
    check_eq("bp_rsp_count", 32'(k), 32'd5);
    cmd_if.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("bp_no_extra", 32'(cmd_if.rsp_valid), 32'd0);
    check_eq("bp_idle", 32'(busy), 32'd0);

    // Reset in WAIT with two requests queued
    ena_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (alu_ena) ena_seen++;
      cmd_if.req_op    = 2'b10;
      cmd_if.req_a     = 3'(i + 2);
      cmd_if.req_b     = 3'd3;
      cmd_if.req_valid = 1'b1;
      @(posedge clk);
    end
    #1;
    cmd_if.req_valid = 1'b0;
    rst = 1'b1;
    check_eq("mid_issue_seen", 32'(ena_seen), 32'd1);
    @(negedge clk);
    check_eq("mid_wait_busy", 32'(busy), 32'd1);
    check_eq("mid_rst_ready", 32'(cmd_if.req_ready), 32'd0);
    @(negedge clk);
    check_eq("mid_rst_ena", 32'(alu_ena), 32'd0);
    check_eq("mid_rst_valid", 32'(cmd_if.rsp_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cmd_if.rsp_valid || alu_ena || busy) stray++;
    end
    check_eq("mid_rst_stale", 32'(stray), 32'd0);
    do_op("add11", 2'b00, 3'd1, 3'd1, 8'h09, 6'd2, 1'b0, 1'b0, 2, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
